// File: rtl/ula_wb_stage_if.sv
// ula_wb_stage_if: bundles the ALU-result input side and the register-file
// write-back side of the write-back stage. The master modport is the
// ALU/register-file environment; the slave modport is the stage itself.
interface ula_wb_stage_if #(
    parameter int bits = 16,
    parameter int AW   = 4
);
    // ALU result input
    logic            in_valid;
    logic            in_ready;
    logic [bits-1:0] in_resu;
    logic            in_o;
    logic            in_c;
    logic            in_s;
    logic            in_z;
    logic [7:0]      in_op;
    logic [AW-1:0]   in_rd;
    logic            in_we;
    logic            in_fwe;

    // register-file write port
    logic            wb_valid;
    logic            wb_ready;
    logic [bits-1:0] wb_data;
    logic [AW-1:0]   wb_addr;

    // architectural flags
    logic            flag_o;
    logic            flag_c;
    logic            flag_s;
    logic            flag_z;

    // forwarding source
    logic            fwd_valid;
    logic [AW-1:0]   fwd_addr;
    logic [bits-1:0] fwd_data;

    modport master (
        output in_valid, in_resu, in_o, in_c, in_s, in_z, in_op, in_rd, in_we, in_fwe,
        output wb_ready,
        input  in_ready, wb_valid, wb_data, wb_addr,
        input  flag_o, flag_c, flag_s, flag_z,
        input  fwd_valid, fwd_addr, fwd_data
    );

    modport slave (
        input  in_valid, in_resu, in_o, in_c, in_s, in_z, in_op, in_rd, in_we, in_fwe,
        input  wb_ready,
        output in_ready, wb_valid, wb_data, wb_addr,
        output flag_o, flag_c, flag_s, flag_z,
        output fwd_valid, fwd_addr, fwd_data
    );
endinterface

// File: rtl/ula_wb_stage.sv
// ula_wb_stage: write-back stage behind the 16-bit ALU.
// Buffers ALU results in a 2-entry FIFO drained through a valid/ready port,
// holds the architectural O/C/S/Z flag register and, when the macro
// ULA_WB_FWD_EN is defined, exposes the youngest pending entry (the FIFO
// tail) as a forwarding source. Without the macro the forwarding outputs
// are tied to zero. All outputs come straight from registers.
module ula_wb_stage #(
    parameter int bits = 16,
    parameter int AW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    ula_wb_stage_if.slave      bus
);

    // FIFO storage and control state
    logic [bits-1:0] mem_data_r [2];
    logic [AW-1:0]   mem_addr_r [2];
    logic            rd_ptr_r;
    logic            wr_ptr_r;
    logic [1:0]      count_r;

    // registered outputs
    logic            in_ready_r;
    logic            wb_valid_r;
    logic [bits-1:0] wb_data_r;
    logic [AW-1:0]   wb_addr_r;
    logic            flag_o_r;
    logic            flag_c_r;
    logic            flag_s_r;
    logic            flag_z_r;

    // next-state terms
    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic            flag_upd_s;
    logic [1:0]      count_next_s;
    logic            rd_ptr_next_s;
    logic            wr_ptr_next_s;
    logic [bits-1:0] head_data_next_s;
    logic [AW-1:0]   head_addr_next_s;

    // Opcode operation/R bits are decoded upstream; only the format field matters here.
    logic            op_unused_s;
    assign op_unused_s = ^bus.in_op[5:0];

    // Handshake decode, occupancy/pointer update and next head selection.
    always_comb begin
        accept_s         = bus.in_valid && (count_r != 2'd2);
        push_s           = accept_s && bus.in_we;
        pop_s            = (count_r != 2'd0) && bus.wb_ready;
        flag_upd_s       = accept_s && bus.in_fwe && (bus.in_op[7:6] == 2'b10);
        count_next_s     = count_r;
        rd_ptr_next_s    = rd_ptr_r;
        wr_ptr_next_s    = wr_ptr_r;
        head_data_next_s = wb_data_r;
        head_addr_next_s = wb_addr_r;

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase

        if (push_s) begin
            wr_ptr_next_s = ~wr_ptr_r;
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = ~rd_ptr_r;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // An empty FIFO keeps presenting the last popped entry.
        if (count_next_s != 2'd0) begin
            if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
                head_data_next_s = bus.in_resu;
                head_addr_next_s = bus.in_rd;
            end else begin
                head_data_next_s = mem_data_r[rd_ptr_next_s];
                head_addr_next_s = mem_addr_r[rd_ptr_next_s];
            end
        end else begin
            head_data_next_s = wb_data_r;
            head_addr_next_s = wb_addr_r;
        end
    end

    // FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_data_r[0] <= {bits{1'b0}};
            mem_data_r[1] <= {bits{1'b0}};
            mem_addr_r[0] <= {AW{1'b0}};
            mem_addr_r[1] <= {AW{1'b0}};
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= bus.in_resu;
                mem_addr_r[wr_ptr_r] <= bus.in_rd;
            end
            rd_ptr_r <= rd_ptr_next_s;
            wr_ptr_r <= wr_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Handshake and head-entry output registers, derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_r <= 1'b1;
            wb_valid_r <= 1'b0;
            wb_data_r  <= {bits{1'b0}};
            wb_addr_r  <= {AW{1'b0}};
        end else begin
            in_ready_r <= (count_next_s != 2'd2);
            wb_valid_r <= (count_next_s != 2'd0);
            wb_data_r  <= head_data_next_s;
            wb_addr_r  <= head_addr_next_s;
        end
    end

    // Architectural flag register: all four load together on an ALU-format update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_o_r <= 1'b0;
            flag_c_r <= 1'b0;
            flag_s_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else if (flag_upd_s) begin
            flag_o_r <= bus.in_o;
            flag_c_r <= bus.in_c;
            flag_s_r <= bus.in_s;
            flag_z_r <= bus.in_z;
        end
    end

    assign bus.in_ready = in_ready_r;
    assign bus.wb_valid = wb_valid_r;
    assign bus.wb_data  = wb_data_r;
    assign bus.wb_addr  = wb_addr_r;
    assign bus.flag_o   = flag_o_r;
    assign bus.flag_c   = flag_c_r;
    assign bus.flag_s   = flag_s_r;
    assign bus.flag_z   = flag_z_r;

`ifdef ULA_WB_FWD_EN
    logic            fwd_valid_r;
    logic [AW-1:0]   fwd_addr_r;
    logic [bits-1:0] fwd_data_r;

    // Forwarding source tracks the most recent push; the tail is always the youngest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_valid_r <= 1'b0;
            fwd_addr_r  <= {AW{1'b0}};
            fwd_data_r  <= {bits{1'b0}};
        end else begin
            fwd_valid_r <= (count_next_s != 2'd0);
            if (push_s) begin
                fwd_addr_r <= bus.in_rd;
                fwd_data_r <= bus.in_resu;
            end
        end
    end

    assign bus.fwd_valid = fwd_valid_r;
    assign bus.fwd_addr  = fwd_addr_r;
    assign bus.fwd_data  = fwd_data_r;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_addr  = {AW{1'b0}};
    assign bus.fwd_data  = {bits{1'b0}};
`endif

endmodule

// File: tb/tb_ula_wb_stage.sv
// tb_ula_wb_stage: table-driven directed vectors, hand-written forwarding
// and asynchronous-reset sequences, and randomized traffic checked against
// a queue-based reference model of the write-back stage.
module tb_ula_wb_stage;

    logic clk;
    logic reset;

    ula_wb_stage_if #(.bits(16), .AW(4)) bus ();

    ula_wb_stage #(.bits(16), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] resu;
        logic [3:0]  rd;
        logic        we;
        logic        fwe;
        logic [7:0]  op;
        logic [3:0]  fl;      // {o,c,s,z}
        logic        ready;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_wv;
        logic [15:0] e_data;
        logic [3:0]  e_addr;
        logic        e_ir;
        logic [3:0]  e_fl;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  a;
    } ent_t;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    ent_t       q[$];
    ent_t       exp_head;
    ent_t       exp_tail;
    logic [3:0] mfl;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic v, input logic [15:0] d, input logic [3:0] rd,
                                 input logic we, input logic fwe, input logic [7:0] op,
                                 input logic [3:0] fl, input logic rdy);
        stim_t s;
        s.valid = v; s.resu = d; s.rd = rd; s.we = we; s.fwe = fwe;
        s.op = op; s.fl = fl; s.ready = rdy;
        return s;
    endfunction

    function automatic vec_t mv(input stim_t s, input logic wv, input logic [15:0] d,
                                input logic [3:0] a, input logic ir, input logic [3:0] fl);
        vec_t v;
        v.s = s; v.e_wv = wv; v.e_data = d; v.e_addr = a; v.e_ir = ir; v.e_fl = fl;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_head = '0;
        exp_tail = '0;
        mfl      = 4'b0000;
    endtask

    // Reference model: one clock edge of behaviour, from the pre-edge queue state.
    task automatic model_step(input stim_t s);
        int   cnt;
        logic acc;
        logic pop;
        ent_t e;
        cnt = q.size();
        acc = s.valid && (cnt < 2);
        pop = (cnt != 0) && s.ready;
        if (acc && s.fwe && (s.op[7:6] == 2'b10)) mfl = s.fl;
        if (pop) e = q.pop_front();
        if (acc && s.we) begin
            e.d = s.resu;
            e.a = s.rd;
            q.push_back(e);
        end
        if (q.size() != 0) begin
            exp_head = q[0];
            exp_tail = q[$];
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] fl;
        fl = {bus.flag_o, bus.flag_c, bus.flag_s, bus.flag_z};
        chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'(q.size() != 0));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(q.size() < 2));
        chk({tag, ".wb_data"},  32'(bus.wb_data),  32'(exp_head.d));
        chk({tag, ".wb_addr"},  32'(bus.wb_addr),  32'(exp_head.a));
        chk({tag, ".flags"},    32'(fl),           32'(mfl));
`ifdef ULA_WB_FWD_EN
        chk({tag, ".fwd_valid"}, 32'(bus.fwd_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ".fwd_data"}, 32'(bus.fwd_data), 32'(exp_tail.d));
            chk({tag, ".fwd_addr"}, 32'(bus.fwd_addr), 32'(exp_tail.a));
        end
`else
        chk({tag, ".fwd_off"}, {bus.fwd_valid, 11'd0, bus.fwd_addr, bus.fwd_data}, 32'd0);
`endif
    endtask

    task automatic drive(input stim_t s);
        bus.in_valid = s.valid;
        bus.in_resu  = s.resu;
        bus.in_rd    = s.rd;
        bus.in_we    = s.we;
        bus.in_fwe   = s.fwe;
        bus.in_op    = s.op;
        {bus.in_o, bus.in_c, bus.in_s, bus.in_z} = s.fl;
        bus.wb_ready = s.ready;
    endtask

    task automatic cycle(input stim_t s, input string tag);
        drive(s);
        @(posedge clk);
        model_step(s);
        #1;
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".wb_valid"}, 32'(bus.wb_valid), 32'd0);
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, ".flags"},    32'({bus.flag_o, bus.flag_c, bus.flag_s, bus.flag_z}), 32'd0);
        chk({tag, ".wb_bus"},   {12'd0, bus.wb_addr, bus.wb_data}, 32'd0);
        chk({tag, ".fwd"},      {bus.fwd_valid, 11'd0, bus.fwd_addr, bus.fwd_data}, 32'd0);
    endtask

    stim_t idle0, idle1, r;

    initial begin
        idle0 = mk(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
        idle1 = mk(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1);

        // directed sequence: {stimulus} -> {wb_valid, wb_data, wb_addr, in_ready, flags} after the edge
        tbl[0]  = mv(idle0,                                                            1'b0, 16'h0000, 4'd0, 1'b1, 4'b0000);
        tbl[1]  = mv(mk(1'b1, 16'h1234, 4'd3, 1'b1, 1'b1, 8'h80, 4'b0100, 1'b0),      1'b1, 16'h1234, 4'd3, 1'b1, 4'b0100);
        tbl[2]  = mv(idle1,                                                            1'b0, 16'h1234, 4'd3, 1'b1, 4'b0100);
        tbl[3]  = mv(mk(1'b1, 16'h0001, 4'd1, 1'b1, 1'b0, 8'h00, 4'b1111, 1'b0),      1'b1, 16'h0001, 4'd1, 1'b1, 4'b0100);
        tbl[4]  = mv(mk(1'b1, 16'h0002, 4'd2, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0),      1'b1, 16'h0001, 4'd1, 1'b0, 4'b0100);
        tbl[5]  = mv(mk(1'b1, 16'h0003, 4'd3, 1'b1, 1'b1, 8'h80, 4'b1111, 1'b0),      1'b1, 16'h0001, 4'd1, 1'b0, 4'b0100);
        tbl[6]  = mv(idle1,                                                            1'b1, 16'h0002, 4'd2, 1'b1, 4'b0100);
        tbl[7]  = mv(mk(1'b1, 16'h00AA, 4'd4, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b1),      1'b1, 16'h00AA, 4'd4, 1'b1, 4'b0100);
        tbl[8]  = mv(mk(1'b1, 16'h0055, 4'd6, 1'b0, 1'b1, 8'h40, 4'b1001, 1'b0),      1'b1, 16'h00AA, 4'd4, 1'b1, 4'b0100);
        tbl[9]  = mv(mk(1'b1, 16'h0066, 4'd7, 1'b0, 1'b1, 8'h88, 4'b0001, 1'b0),      1'b1, 16'h00AA, 4'd4, 1'b1, 4'b0001);
        tbl[10] = mv(idle1,                                                            1'b0, 16'h00AA, 4'd4, 1'b1, 4'b0001);

        // reset asserted from time zero, released on a falling edge
        reset = 1'b1;
        drive(idle0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) cycle(idle0, "idle");

        // table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].s, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.wb_valid", i), 32'(bus.wb_valid), 32'(tbl[i].e_wv));
            chk($sformatf("tbl%0d.wb_data", i),  32'(bus.wb_data),  32'(tbl[i].e_data));
            chk($sformatf("tbl%0d.wb_addr", i),  32'(bus.wb_addr),  32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d.in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d.flags", i),
                32'({bus.flag_o, bus.flag_c, bus.flag_s, bus.flag_z}), 32'(tbl[i].e_fl));
        end

        // forwarding: two pending writes to r5, the younger one is forwarded
        cycle(mk(1'b1, 16'h0010, 4'd5, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0), "fwd1");
        cycle(mk(1'b1, 16'h0020, 4'd5, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0), "fwd2");
`ifdef ULA_WB_FWD_EN
        chk("fwd.valid", 32'(bus.fwd_valid), 32'd1);
        chk("fwd.addr",  32'(bus.fwd_addr),  32'd5);
        chk("fwd.data",  32'(bus.fwd_data),  32'h0020);
`else
        chk("fwd.valid_off", 32'(bus.fwd_valid), 32'd0);
`endif
        chk("fwd.head", 32'(bus.wb_data), 32'h0010);
        cycle(idle0, "stall");
        chk("stall.head", 32'(bus.wb_data), 32'h0010);
        cycle(idle1, "drain1");
        chk("drain1.head", 32'(bus.wb_data), 32'h0020);
        cycle(idle1, "drain2");

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            r.valid = ($urandom_range(0, 3) != 0);
            r.resu  = 16'($urandom);
            r.rd    = 4'($urandom);
            r.we    = ($urandom_range(0, 4) != 0);
            r.fwe   = 1'($urandom);
            r.op    = 8'($urandom);
            r.fl    = 4'($urandom);
            r.ready = ($urandom_range(0, 2) != 0);
            cycle(r, "rand");
        end

        // fill the FIFO, then assert reset between clock edges
        cycle(mk(1'b1, 16'hBEEF, 4'd9, 1'b1, 1'b1, 8'h80, 4'b1111, 1'b0), "pre1");
        cycle(mk(1'b1, 16'hCAFE, 4'd8, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0), "pre2");
        drive(idle0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle(idle0, "post_reset_idle");
        cycle(idle1, "post_reset_ready");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ula_wb_stage.md
# ula_wb_stage

Write-back stage directly downstream of the 16-bit ALU. It accepts one ALU result per cycle together with its O/C/S/Z flags, the destination register and the opcode, and holds the architectural flag register. Results are buffered in a 2-entry FIFO and drained to the register-file write port through a valid/ready handshake. Optionally, the youngest pending result is exposed as a forwarding source for the operand-select logic upstream of the ALU.

## Interface
- `bits`, default 16: data width; must match the ALU.
- `AW`, default 4: register address width (16 registers).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: ALU result presented this cycle.
- `in_ready` output 1: stage can accept; equals (count < 2); no combinational dependence on `wb_ready`.
- `in_resu` input `bits`: ALU result, signed.
- `in_o`, `in_c`, `in_s`, `in_z` input 1 each: ALU flags.
- `in_op` input 8: opcode. [7:6] is the constant format, [5] is R, [4:0] is the operation.
- `in_rd` input `AW`: destination register.
- `in_we` input 1: result is written to the register file.
- `in_fwe` input 1: instruction may update flags.
- `wb_valid` output 1: head entry available.
- `wb_ready` input 1: register file consumes the head entry.
- `wb_data` output `bits`: head entry data.
- `wb_addr` output `AW`: head entry register.
- `flag_o`, `flag_c`, `flag_s`, `flag_z` output 1 each: architectural flag register.
- `fwd_valid` output 1: forwarding entry valid.
- `fwd_addr` output `AW`: forwarding entry register.
- `fwd_data` output `bits`: forwarding entry data.

## Operation
- Accept occurs when `in_valid && in_ready`.
- On accept with `in_we=1`, {`in_resu`, `in_rd`} is pushed at the tail of the FIFO. With `in_we=0`, nothing is pushed; only the flags may change.
- Flag update happens on accept when `in_fwe=1 && in_op[7:6]==2'b10` (ALU arithmetic/logic path).
  - All four flag registers load `in_o`, `in_c`, `in_s`, `in_z` together.
  - Otherwise (constant-format ops, or `in_fwe=0`) the flags hold.
  - Flags update even when `in_we=0` (compare-style ops).
- Pop occurs when `wb_valid && wb_ready`: the head is retired and the next entry, if any, becomes the head.
- FIFO:
  - Storage is 2 entries, with read pointer, write pointer and a count of 0..2.
  - Both pointers wrap 1 to 0.
  - `wb_valid = (count != 0)`.
  - `wb_data` and `wb_addr` come from the head entry. When count = 0 they drive the last popped value; the consumer must not sample them.
- Simultaneous push and pop:
  - At count = 1: count stays 1, and the head advances to the newly pushed entry.
  - At count = 0: push only, because pop requires `wb_valid`.
  - At count = 2: `in_ready=0`, so pop only.
- Pushes with `in_we=0` never change count, even when `in_valid` is high.
- Forwarding:
  - The forwarding entry is the most recently pushed entry still in the FIFO (the tail).
  - `fwd_valid = (count != 0)`.
  - When two pending entries target the same register, only the younger is forwarded.
- Arithmetic: no width conversion; data is stored bit-exact.

## Timing
- Reset values:
  - `wb_valid=0`, `in_ready=1`, `fwd_valid=0`.
  - All flags 0.
  - `wb_data`, `wb_addr`, `fwd_data`, `fwd_addr` all 0.
  - Pointers and count 0.
- Latency: an entry accepted at edge N has `wb_valid=1` in the cycle after edge N, one cycle of latency. A pushed flag update is visible after edge N.
- Throughput: 1 result per cycle while `wb_ready` is held high.
- `in_ready` is registered-state only (function of count). It drops in the cycle after the second outstanding entry is pushed.
- An asserted `reset` mid-operation clears the FIFO immediately and discards pending entries. The flags return to 0 asynchronously.
- `wb_valid` and `wb_data` stay stable while `wb_valid && !wb_ready`.

## Configuration
- Macro: `ULA_WB_FWD_EN`.
- Defined: forwarding outputs behave as in Operation.
- Undefined: `fwd_valid`, `fwd_addr` and `fwd_data` are tied to 0, and no forwarding mux is synthesized. All other behaviour is identical.

## Test plan
- Reset then idle:
  - Assert `reset` asynchronously mid-cycle: all outputs are 0 at once and `in_ready=1`.
  - Release reset, drive `in_valid=0` for 5 cycles: `wb_valid` stays 0.
- Single result:
  - Push `in_resu=16'h1234`, `in_rd=3`, `in_we=1`, `in_fwe=1`, `in_op=8'h80`, flags O=0 C=1 S=0 Z=0.
  - Next cycle: `wb_valid=1`, `wb_data=16'h1234`, `wb_addr=3`, `flag_c=1`.
  - `wb_ready=1`: `wb_valid=0` one cycle later.
- Backpressure and full:
  - Hold `wb_ready=0` and push `16'h0001` to r1, then `16'h0002` to r2.
  - `in_ready=0` after the second push, and a third `in_valid` is ignored.
  - Release `wb_ready`: data drains in order 0001, then 0002.
- Simultaneous push and pop at count = 1: head 0001 pending, push `16'h00AA` while `wb_ready=1` → count stays 1 and the next `wb_data=16'h00AA`.
- Flag gating:
  - `in_op=8'h40` (constant format), `in_fwe=1`, Z=1: flags unchanged.
  - `in_op=8'h88`, `in_we=0`, `in_fwe=1`, Z=1: `flag_z=1`, no FIFO entry.
- Forwarding with `ULA_WB_FWD_EN` defined:
  - Push r5=`16'h0010`, then r5=`16'h0020` with `wb_ready=0`: `fwd_addr=5`, `fwd_data=16'h0020`.
  - Rebuild without the macro: `fwd_valid` stays 0.
